// File: rtl/car_sprite_pkg.sv
// Shared sprite geometry and palette for the player's formula car.
// The renderer and collision logic reuse the dimensions and region bounds from here.
package car_sprite_pkg;

    localparam logic [9:0]  SPR_W     = 10'd30;
    localparam logic [9:0]  SPR_H     = 10'd30;

    localparam logic [11:0] KEY_COLOR = 12'h0F0;
    localparam logic [11:0] BODY      = 12'hF00;
    localparam logic [11:0] WING      = 12'h222;
    localparam logic [11:0] TIRE      = 12'h111;
    localparam logic [11:0] HELMET    = 12'hFF0;

    // Region bounds, inclusive; row 0 is the nose, car facing up.
    localparam logic [9:0] HELMET_ROW_LO = 10'd13;
    localparam logic [9:0] HELMET_ROW_HI = 10'd16;
    localparam logic [9:0] HELMET_COL_LO = 10'd13;
    localparam logic [9:0] HELMET_COL_HI = 10'd16;

    localparam logic [9:0] FWING_ROW_LO  = 10'd1;
    localparam logic [9:0] FWING_ROW_HI  = 10'd3;
    localparam logic [9:0] FWING_COL_LO  = 10'd3;
    localparam logic [9:0] FWING_COL_HI  = 10'd26;

    localparam logic [9:0] RWING_ROW_LO  = 10'd27;
    localparam logic [9:0] RWING_ROW_HI  = 10'd29;
    localparam logic [9:0] RWING_COL_LO  = 10'd4;
    localparam logic [9:0] RWING_COL_HI  = 10'd25;

    localparam logic [9:0] FTIRE_ROW_LO  = 10'd5;
    localparam logic [9:0] FTIRE_ROW_HI  = 10'd11;
    localparam logic [9:0] FTIRE_LCOL_LO = 10'd1;
    localparam logic [9:0] FTIRE_LCOL_HI = 10'd5;
    localparam logic [9:0] FTIRE_RCOL_LO = 10'd24;
    localparam logic [9:0] FTIRE_RCOL_HI = 10'd28;

    localparam logic [9:0] RTIRE_ROW_LO  = 10'd18;
    localparam logic [9:0] RTIRE_ROW_HI  = 10'd26;
    localparam logic [9:0] RTIRE_LCOL_LO = 10'd0;
    localparam logic [9:0] RTIRE_LCOL_HI = 10'd5;
    localparam logic [9:0] RTIRE_RCOL_LO = 10'd24;
    localparam logic [9:0] RTIRE_RCOL_HI = 10'd29;

    localparam logic [9:0] NOSE_ROW_LO   = 10'd0;
    localparam logic [9:0] NOSE_ROW_HI   = 10'd12;
    localparam logic [9:0] NOSE_COL_LO   = 10'd12;
    localparam logic [9:0] NOSE_COL_HI   = 10'd17;

    localparam logic [9:0] CHAS_ROW_LO   = 10'd13;
    localparam logic [9:0] CHAS_ROW_HI   = 10'd25;
    localparam logic [9:0] CHAS_COL_LO   = 10'd9;
    localparam logic [9:0] CHAS_COL_HI   = 10'd20;

    function automatic logic in_box(input logic [9:0] r, input logic [9:0] c,
                                    input logic [9:0] r_lo, input logic [9:0] r_hi,
                                    input logic [9:0] c_lo, input logic [9:0] c_hi);
        return (r >= r_lo) && (r <= r_hi) && (c >= c_lo) && (c <= c_hi);
    endfunction

endpackage

// File: rtl/car_region_decode.sv
// Combinational region lookup: maps an in-sprite (row,col) to its palette colour.
module car_region_decode
    import car_sprite_pkg::*;
(
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    output logic [11:0] color
);

    logic hit_helmet_s;
    logic hit_wing_s;
    logic hit_tire_s;
    logic hit_body_s;

    assign hit_helmet_s = in_box(row, col, HELMET_ROW_LO, HELMET_ROW_HI, HELMET_COL_LO, HELMET_COL_HI);

    assign hit_wing_s   = in_box(row, col, FWING_ROW_LO, FWING_ROW_HI, FWING_COL_LO, FWING_COL_HI)
                        | in_box(row, col, RWING_ROW_LO, RWING_ROW_HI, RWING_COL_LO, RWING_COL_HI);

    assign hit_tire_s   = in_box(row, col, FTIRE_ROW_LO, FTIRE_ROW_HI, FTIRE_LCOL_LO, FTIRE_LCOL_HI)
                        | in_box(row, col, FTIRE_ROW_LO, FTIRE_ROW_HI, FTIRE_RCOL_LO, FTIRE_RCOL_HI)
                        | in_box(row, col, RTIRE_ROW_LO, RTIRE_ROW_HI, RTIRE_LCOL_LO, RTIRE_LCOL_HI)
                        | in_box(row, col, RTIRE_ROW_LO, RTIRE_ROW_HI, RTIRE_RCOL_LO, RTIRE_RCOL_HI);

    assign hit_body_s   = in_box(row, col, NOSE_ROW_LO, NOSE_ROW_HI, NOSE_COL_LO, NOSE_COL_HI)
                        | in_box(row, col, CHAS_ROW_LO, CHAS_ROW_HI, CHAS_COL_LO, CHAS_COL_HI);

    // Priority encode overlapping regions: helmet over wing over tyre over body.
    always_comb begin
        color = KEY_COLOR;
        if (hit_helmet_s) begin
            color = HELMET;
        end else if (hit_wing_s) begin
            color = WING;
        end else if (hit_tire_s) begin
            color = TIRE;
        end else if (hit_body_s) begin
            color = BODY;
        end else begin
            color = KEY_COLOR;
        end
    end

endmodule

// File: rtl/formula_car_rom.sv
// Formula car sprite ROM: range check on full 10-bit coordinates, region decode,
// and a one-cycle registered colour output that is forced to the key colour in reset.
module formula_car_rom
    import car_sprite_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    output logic [11:0] color_data
);

    logic        in_range_s;
    logic [11:0] region_color_s;
    logic [11:0] next_color_s;

    assign in_range_s = (row < SPR_H) && (col < SPR_W);

    car_region_decode u_decode (
        .row   (row),
        .col   (col),
        .color (region_color_s)
    );

    // Anything outside the 30x30 box, including wrapped negatives, is transparent.
    always_comb begin
        next_color_s = KEY_COLOR;
        if (in_range_s) begin
            next_color_s = region_color_s;
        end else begin
            next_color_s = KEY_COLOR;
        end
    end

    // Output register; reset drives the key colour without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_data <= KEY_COLOR;
        end else begin
            color_data <= next_color_s;
        end
    end

endmodule

// File: tb/tb_formula_car_rom.sv
// Scoreboard bench for formula_car_rom: stimulus pushes expected colours from a
// painted reference image, a monitor pops and compares one cycle later.
module tb_formula_car_rom;

    logic        clk;
    logic        rst;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [11:0] color_data;

    localparam logic [11:0] K_KEY    = 12'h0F0;
    localparam logic [11:0] K_BODY   = 12'hF00;
    localparam logic [11:0] K_WING   = 12'h222;
    localparam logic [11:0] K_TIRE   = 12'h111;
    localparam logic [11:0] K_HELMET = 12'hFF0;

    typedef struct {
        logic [11:0] exp;
        logic [9:0]  r;
        logic [9:0]  c;
        bit          scan;
    } item_t;

    item_t       sb[$];
    logic [11:0] img [30][30];
    logic [11:0] dut_img [30][30];
    int          cnt_helmet, cnt_wing, cnt_tire, cnt_body, cnt_key;
    int          errors = 0;
    int          checks = 0;

    formula_car_rom dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .color_data (color_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Painter's model: fill lowest priority first, later regions overwrite.
    task automatic paint(input int r0, input int r1, input int c0, input int c1, input logic [11:0] v);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                img[r][c] = v;
    endtask

    function automatic logic [11:0] ref_color(input int r, input int c);
        if (r >= 30 || c >= 30) return K_KEY;
        return img[r][c];
    endfunction

    task automatic issue(input int r, input int c, input bit scan);
        item_t it;
        @(posedge clk);
        #2;
        row = 10'(r);
        col = 10'(c);
        it.exp  = ref_color(r, c);
        it.r    = 10'(r);
        it.c    = 10'(c);
        it.scan = scan;
        sb.push_back(it);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid", color_data, K_KEY);
        @(posedge clk);
        #1;
        check("reset_held_edge", color_data, K_KEY);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every sample issued before an edge is compared just after that edge.
    always begin
        item_t it;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check($sformatf("pix(%0d,%0d)", it.r, it.c), color_data, it.exp);
            if (it.scan) begin
                dut_img[it.r][it.c] = color_data;
                if (color_data == K_HELMET)    cnt_helmet++;
                else if (color_data == K_WING) cnt_wing++;
                else if (color_data == K_TIRE) cnt_tire++;
                else if (color_data == K_BODY) cnt_body++;
                else                           cnt_key++;
            end
        end
    end

    initial begin
        int dr[13] = '{14, 0, 2, 8, 20, 28, 0, 30, 5, 1023, 29, 29, 12};
        int dc[13] = '{14, 14, 14, 3, 10, 4, 0, 5, 30, 1023, 29, 25, 17};
        int drain;

        cnt_helmet = 0; cnt_wing = 0; cnt_tire = 0; cnt_body = 0; cnt_key = 0;
        paint(0, 29, 0, 29, K_KEY);
        paint(0, 12, 12, 17, K_BODY);
        paint(13, 25, 9, 20, K_BODY);
        paint(5, 11, 1, 5, K_TIRE);
        paint(5, 11, 24, 28, K_TIRE);
        paint(18, 26, 0, 5, K_TIRE);
        paint(18, 26, 24, 29, K_TIRE);
        paint(1, 3, 3, 26, K_WING);
        paint(27, 29, 4, 25, K_WING);
        paint(13, 16, 13, 16, K_HELMET);

        rst = 1'b1;
        row = 10'd5;
        col = 10'd5;
        #1;
        check("reset_no_clock", color_data, K_KEY);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) issue(dr[i], dc[i], 1'b0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) issue($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
            else                           issue($urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
        end

        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 30; c++) begin
                if (r == 15 && c == 0) pulse_reset();
                issue(r, c, 1'b1);
            end
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d samples never compared, expected 0", sb.size());
        end

        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 15; c++)
                check($sformatf("mirror(%0d,%0d)", r, c), dut_img[r][c], dut_img[r][29 - c]);

        checks += 5;
        if (cnt_helmet != 16)  begin errors++; $display("FAIL count_helmet: got %0d expected 16", cnt_helmet); end
        if (cnt_wing   != 138) begin errors++; $display("FAIL count_wing: got %0d expected 138", cnt_wing); end
        if (cnt_tire   != 178) begin errors++; $display("FAIL count_tire: got %0d expected 178", cnt_tire); end
        if (cnt_body   != 200) begin errors++; $display("FAIL count_body: got %0d expected 200", cnt_body); end
        if (cnt_key    != 368) begin errors++; $display("FAIL count_key: got %0d expected 368", cnt_key); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
